regfile_bypass: RTL and testbench
=================================

Name: regfile_bypass

Overview:
- Parametrised successor to the decode-stage 4x8 register file.
- Provides N registers of DATA_W bits, two combinational read ports and three prioritised synchronous write ports (immediate-load, writeback, data-memory).
- Adds same-cycle write-to-read bypass and a per-register pending scoreboard that raises a stall when a read hits an unresolved destination.
- Sits in DE_stg between instruction decode and the EX stage.

Parameters:
- DATA_W, 8, register width in bits
- NREGS, 4, number of architectural registers (power of two, >=2)
- ADDR_W, 2, register index width, must equal log2(NREGS)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- rd_a_addr  in  ADDR_W  read port A index (Ra)
- rd_b_addr  in  ADDR_W  read port B index (Rb)
- rd_a_en  in  1  port A read is live (counts for stall)
- rd_b_en  in  1  port B read is live (counts for stall)
- rd_a_data  out  DATA_W  port A data, bypassed
- rd_b_data  out  DATA_W  port B data, bypassed
- li_we  in  1  immediate-load write enable (decode stage)
- li_addr  in  ADDR_W  immediate-load destination
- li_data  in  DATA_W  immediate value
- wb_we  in  1  writeback write enable (ALU result)
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- dm_we  in  1  data-memory load write enable
- dm_addr  in  ADDR_W  data-memory destination
- dm_data  in  DATA_W  loaded value
- issue_valid  in  1  instruction with a destination issues this cycle
- issue_dst  in  ADDR_W  its destination index
- out_latch  in  1  capture register 0 into final_output
- stall  out  1  read of pending, non-bypassable register
- pending  out  NREGS  scoreboard bit per register
- final_output  out  DATA_W  registered copy of register 0
- reg_dump  out  NREGS*DATA_W  flattened register contents, reg i at [i*DATA_W +: DATA_W]

Behaviour:
- Reset (sync, active-high): all registers 0, pending 0, final_output 0. Reset wins over every write, issue and latch in that cycle.
- Writes commit at the rising edge; 1-cycle latency to reg_dump.
- Write-port priority on the same index in the same cycle: dm > wb > li. Writes to different indices all commit in parallel.
- Read data is combinational. If any enabled write targets the read index, the highest-priority write data is returned (write-first bypass); otherwise the stored value is returned.
- rd_*_data is valid regardless of rd_*_en; the enables affect only stall.
- Scoreboard, per register i, at each edge:
  - set if issue_valid and issue_dst==i
  - else clear if any write targets i
  - set wins over a clear in the same cycle (a new producer supersedes the old one)
- stall = (rd_a_en & pending[rd_a_addr] & no write to rd_a_addr this cycle) | (same term for port B). Combinational; the block itself does not hold state on stall.
- li writes do not require pending; they clear it like any other write.
- final_output loads register 0's bypassed value on out_latch and holds otherwise.
- No illegal states; ADDR_W/NREGS mismatch is a static elaboration error.

Decomposition:
- Shared package holds:
  - write-port priority encoding constants (WP_DM, WP_WB, WP_LI)
  - default DATA_W/NREGS
  - function for index-to-onehot decode
- One natural sub-module: regfile_wr_mux, the per-index 3-way priority select producing write enable and data. It is reused by both the storage update and the bypass path so the two cannot diverge.

Test Plan:
- Reset then read all indices -> all 0, pending 0, stall 0, final_output 0.
- Same-cycle collision: li_we to r2=0x11, wb_we to r2=0x22, dm_we to r2=0x33 -> rd_a_addr=2 reads 0x33 that cycle; reg_dump r2=0x33 after the edge.
- Bypass: wb_we r1=0xA5 with rd_b_addr=1 -> rd_b_data=0xA5 in the same cycle, before commit.
- Scoreboard: issue_valid dst=3; next cycle rd_a_en addr=3 with no write -> stall=1. Then dm_we r3=0x7E with the read in the same cycle -> stall=0, data 0x7E, pending[3] clears.
- Set-over-clear: issue_valid dst=0 with wb_we r0=0x05 in the same cycle -> r0=0x05, pending[0]=1 after the edge.
- Reset mid-operation: pending=4'b1010 and wb_we asserted with reset=1 -> next cycle all registers 0 and pending 0. Also out_latch with r0=0x42 -> final_output=0x42 the following cycle.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// Shared definitions for the bypassed register file: write-port priority
// codes, default geometry and the index-to-onehot decoder.
package regfile_bypass_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NREGS  = 4;
    localparam int MAX_REGS   = 64;

    // Higher code means higher priority when several ports hit one index.
    typedef enum logic [1:0] {
        WP_NONE = 2'd0,
        WP_LI   = 2'd1,
        WP_WB   = 2'd2,
        WP_DM   = 2'd3
    } wp_e;

    function automatic logic [MAX_REGS-1:0] idx2onehot(input logic [31:0] idx);
        return {{(MAX_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// Bus bundle between decode control and the bypassed register file.
interface regfile_bypass_if
    import regfile_bypass_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0]       rd_a_addr;
    logic [ADDR_W-1:0]       rd_b_addr;
    logic                    rd_a_en;
    logic                    rd_b_en;
    logic [DATA_W-1:0]       rd_a_data;
    logic [DATA_W-1:0]       rd_b_data;
    logic                    li_we;
    logic [ADDR_W-1:0]       li_addr;
    logic [DATA_W-1:0]       li_data;
    logic                    wb_we;
    logic [ADDR_W-1:0]       wb_addr;
    logic [DATA_W-1:0]       wb_data;
    logic                    dm_we;
    logic [ADDR_W-1:0]       dm_addr;
    logic [DATA_W-1:0]       dm_data;
    logic                    issue_valid;
    logic [ADDR_W-1:0]       issue_dst;
    logic                    out_latch;
    logic                    stall;
    logic [NREGS-1:0]        pending;
    logic [DATA_W-1:0]       final_output;
    logic [NREGS*DATA_W-1:0] reg_dump;

    modport master (
        output rd_a_addr, rd_b_addr, rd_a_en, rd_b_en,
        output li_we, li_addr, li_data, wb_we, wb_addr, wb_data,
        output dm_we, dm_addr, dm_data, issue_valid, issue_dst, out_latch,
        input  rd_a_data, rd_b_data, stall, pending, final_output, reg_dump
    );

    modport slave (
        input  rd_a_addr, rd_b_addr, rd_a_en, rd_b_en,
        input  li_we, li_addr, li_data, wb_we, wb_addr, wb_data,
        input  dm_we, dm_addr, dm_data, issue_valid, issue_dst, out_latch,
        output rd_a_data, rd_b_data, stall, pending, final_output, reg_dump
    );

endinterface

// File: rtl/regfile_bypass_wr_mux.sv
// Per-register 3-way write select (dm > wb > li). Feeds both the storage
// update and the read bypass so the two always agree.
module regfile_wr_mux
    import regfile_bypass_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              li_hit_i,
    input  logic              wb_hit_i,
    input  logic              dm_hit_i,
    input  logic [DATA_W-1:0] li_data_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              we_o,
    output logic [DATA_W-1:0] data_o
);

    wp_e sel;

    always_comb begin
        if (dm_hit_i)      sel = WP_DM;
        else if (wb_hit_i) sel = WP_WB;
        else if (li_hit_i) sel = WP_LI;
        else               sel = WP_NONE;
    end

    always_comb begin
        data_o = '0;
        unique case (sel)
            WP_DM:   data_o = dm_data_i;
            WP_WB:   data_o = wb_data_i;
            WP_LI:   data_o = li_data_i;
            default: data_o = '0;
        endcase
    end

    assign we_o = (sel != WP_NONE);

endmodule

// File: rtl/regfile_bypass.sv
// Decode-stage register file: N registers, two bypassed combinational reads,
// three prioritised writes, a pending scoreboard with stall, and a latched r0.
module regfile_bypass
    import regfile_bypass_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    regfile_bypass_if.slave  bus
);

    if (ADDR_W != $clog2(NREGS) || NREGS < 2 || NREGS > MAX_REGS) begin : g_bad_geometry
        $error("regfile_bypass: ADDR_W must equal log2(NREGS), 2 <= NREGS <= 64");
    end

    logic [DATA_W-1:0] regs_q  [NREGS];
    logic [DATA_W-1:0] regs_d  [NREGS];
    logic [NREGS-1:0]  pending_q, pending_d;
    logic [DATA_W-1:0] final_q, final_d;

    logic [NREGS-1:0]  li_hit, wb_hit, dm_hit, issue_hit;
    logic [NREGS-1:0]  wr_we;
    logic [DATA_W-1:0] wr_data [NREGS];
    logic [DATA_W-1:0] byp     [NREGS];

    always_comb begin
        li_hit    = NREGS'(idx2onehot(32'(bus.li_addr)))   & {NREGS{bus.li_we}};
        wb_hit    = NREGS'(idx2onehot(32'(bus.wb_addr)))   & {NREGS{bus.wb_we}};
        dm_hit    = NREGS'(idx2onehot(32'(bus.dm_addr)))   & {NREGS{bus.dm_we}};
        issue_hit = NREGS'(idx2onehot(32'(bus.issue_dst))) & {NREGS{bus.issue_valid}};
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        regfile_wr_mux #(.DATA_W(DATA_W)) u_wr_mux (
            .li_hit_i  (li_hit[i]),
            .wb_hit_i  (wb_hit[i]),
            .dm_hit_i  (dm_hit[i]),
            .li_data_i (bus.li_data),
            .wb_data_i (bus.wb_data),
            .dm_data_i (bus.dm_data),
            .we_o      (wr_we[i]),
            .data_o    (wr_data[i])
        );

        assign byp[i] = wr_we[i] ? wr_data[i] : regs_q[i];
        assign bus.reg_dump[i*DATA_W +: DATA_W] = regs_q[i];
    end

    // A fresh issue supersedes a write landing on the same index this cycle.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i]    = wr_we[i] ? wr_data[i] : regs_q[i];
            pending_d[i] = issue_hit[i] | (pending_q[i] & ~wr_we[i]);
        end
        final_d = bus.out_latch ? byp[0] : final_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            pending_q <= '0;
            final_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            final_q   <= final_d;
        end
    end

    assign bus.rd_a_data    = byp[bus.rd_a_addr];
    assign bus.rd_b_data    = byp[bus.rd_b_addr];
    assign bus.pending      = pending_q;
    assign bus.final_output = final_q;

    // A write landing this cycle resolves the hazard through the bypass.
    assign bus.stall = (bus.rd_a_en & pending_q[bus.rd_a_addr] & ~wr_we[bus.rd_a_addr])
                     | (bus.rd_b_en & pending_q[bus.rd_b_addr] & ~wr_we[bus.rd_b_addr]);

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: a behavioural register-array model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_regfile_bypass;

    localparam int DATA_W = 8;
    localparam int NREGS  = 4;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_bypass_if #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) bus ();

    regfile_bypass #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [DATA_W-1:0] m_regs [NREGS];
    logic [NREGS-1:0]  m_pend  = '0;
    logic [DATA_W-1:0] m_final = '0;

    function automatic logic any_write(input logic [ADDR_W-1:0] a);
        return (bus.li_we && bus.li_addr == a) || (bus.wb_we && bus.wb_addr == a) ||
               (bus.dm_we && bus.dm_addr == a);
    endfunction

    // Apply ports lowest priority first so the strongest write is what remains.
    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = m_regs[a];
        if (bus.li_we && bus.li_addr == a) v = bus.li_data;
        if (bus.wb_we && bus.wb_addr == a) v = bus.wb_data;
        if (bus.dm_we && bus.dm_addr == a) v = bus.dm_data;
        return v;
    endfunction

    function automatic logic m_stall();
        return (bus.rd_a_en && m_pend[bus.rd_a_addr] && !any_write(bus.rd_a_addr)) ||
               (bus.rd_b_en && m_pend[bus.rd_b_addr] && !any_write(bus.rd_b_addr));
    endfunction

    function automatic logic [NREGS*DATA_W-1:0] m_dump();
        logic [NREGS*DATA_W-1:0] d;
        for (int i = 0; i < NREGS; i++) d[i*DATA_W +: DATA_W] = m_regs[i];
        return d;
    endfunction

    initial begin
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
                m_pend  = '0;
                m_final = '0;
            end else begin
                logic [DATA_W-1:0] nf;
                logic [DATA_W-1:0] nr [NREGS];
                nf = bus.out_latch ? m_read('0) : m_final;
                for (int i = 0; i < NREGS; i++) begin
                    if (any_write(ADDR_W'(i))) m_pend[i] = 1'b0;
                    if (bus.issue_valid && bus.issue_dst == ADDR_W'(i)) m_pend[i] = 1'b1;
                    nr[i] = m_read(ADDR_W'(i));
                end
                for (int i = 0; i < NREGS; i++) m_regs[i] = nr[i];
                m_final = nf;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rd_a_data",    64'(bus.rd_a_data),    64'(m_read(bus.rd_a_addr)));
        chk("rd_b_data",    64'(bus.rd_b_data),    64'(m_read(bus.rd_b_addr)));
        chk("stall",        64'(bus.stall),        64'(m_stall()));
        chk("pending",      64'(bus.pending),      64'(m_pend));
        chk("final_output", 64'(bus.final_output), 64'(m_final));
        chk("reg_dump",     64'(bus.reg_dump),     64'(m_dump()));
    end

    task automatic idle();
        bus.rd_a_addr = '0;  bus.rd_b_addr = '0;
        bus.rd_a_en = 1'b0;  bus.rd_b_en = 1'b0;
        bus.li_we = 1'b0;    bus.li_addr = '0;  bus.li_data = '0;
        bus.wb_we = 1'b0;    bus.wb_addr = '0;  bus.wb_data = '0;
        bus.dm_we = 1'b0;    bus.dm_addr = '0;  bus.dm_data = '0;
        bus.issue_valid = 1'b0;  bus.issue_dst = '0;
        bus.out_latch = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr_li(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.li_we = 1'b1; bus.li_addr = a; bus.li_data = d;
    endtask
    task automatic wr_wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    endtask
    task automatic wr_dm(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.dm_we = 1'b1; bus.dm_addr = a; bus.dm_data = d;
    endtask
    task automatic issue(input logic [ADDR_W-1:0] a);
        bus.issue_valid = 1'b1; bus.issue_dst = a;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.rd_a_en = 1'b1; bus.rd_a_addr = 2'd3;
        bus.rd_b_en = 1'b1; bus.rd_b_addr = 2'd2;
        @(negedge clk);
        chk("reset_dump",    64'(bus.reg_dump),     64'h0);
        chk("reset_pending", 64'(bus.pending),      64'h0);
        chk("reset_stall",   64'(bus.stall),        64'h0);
        chk("reset_final",   64'(bus.final_output), 64'h0);

        for (int i = 0; i < NREGS; i++) begin
            cyc();
            bus.rd_a_addr = ADDR_W'(i);
            bus.rd_b_addr = ADDR_W'(NREGS - 1 - i);
            @(negedge clk);
            chk("reset_rd_a", 64'(bus.rd_a_data), 64'h0);
            chk("reset_rd_b", 64'(bus.rd_b_data), 64'h0);
        end

        cyc();
        wr_li(2'd2, 8'h11); wr_wb(2'd2, 8'h22); wr_dm(2'd2, 8'h33);
        bus.rd_a_addr = 2'd2;
        @(negedge clk);
        chk("collision_bypass", 64'(bus.rd_a_data), 64'h33);
        cyc();
        @(negedge clk);
        chk("collision_commit", 64'(bus.reg_dump[2*DATA_W +: DATA_W]), 64'h33);

        cyc();
        wr_wb(2'd1, 8'hA5);
        bus.rd_b_addr = 2'd1;
        @(negedge clk);
        chk("wb_bypass",       64'(bus.rd_b_data), 64'hA5);
        chk("wb_not_yet_stored", 64'(bus.reg_dump[1*DATA_W +: DATA_W]), 64'h0);

        cyc();
        issue(2'd3);
        cyc();
        bus.rd_a_en = 1'b1; bus.rd_a_addr = 2'd3;
        @(negedge clk);
        chk("sb_stall",   64'(bus.stall),   64'h1);
        chk("sb_pending", 64'(bus.pending), 64'h8);
        cyc();
        bus.rd_a_en = 1'b1; bus.rd_a_addr = 2'd3;
        wr_dm(2'd3, 8'h7E);
        @(negedge clk);
        chk("sb_resolve_stall", 64'(bus.stall),     64'h0);
        chk("sb_resolve_data",  64'(bus.rd_a_data), 64'h7E);
        cyc();
        @(negedge clk);
        chk("sb_clear", 64'(bus.pending[3]), 64'h0);

        cyc();
        issue(2'd2);
        cyc();
        bus.rd_b_en = 1'b1; bus.rd_b_addr = 2'd2; bus.rd_a_addr = 2'd2;
        @(negedge clk);
        chk("sb_stall_b", 64'(bus.stall), 64'h1);
        cyc();
        bus.rd_b_en = 1'b1; bus.rd_b_addr = 2'd2;
        wr_li(2'd2, 8'h44);
        @(negedge clk);
        chk("li_resolve_stall", 64'(bus.stall),     64'h0);
        chk("li_resolve_data",  64'(bus.rd_b_data), 64'h44);

        cyc();
        issue(2'd0); wr_wb(2'd0, 8'h05);
        cyc();
        @(negedge clk);
        chk("set_over_clear_r0",  64'(bus.reg_dump[0 +: DATA_W]), 64'h05);
        chk("set_over_clear_pnd", 64'(bus.pending), 64'h1);

        cyc();
        issue(2'd1); wr_wb(2'd0, 8'h06);
        cyc();
        issue(2'd3);
        cyc();
        @(negedge clk);
        chk("pending_1010", 64'(bus.pending), 64'hA);
        cyc();
        reset = 1'b1;
        wr_wb(2'd2, 8'h99); wr_li(2'd1, 8'h11); issue(2'd0);
        bus.out_latch = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_dump",    64'(bus.reg_dump),     64'h0);
        chk("midreset_pending", 64'(bus.pending),      64'h0);
        chk("midreset_final",   64'(bus.final_output), 64'h0);

        cyc();
        wr_li(2'd0, 8'h42);
        cyc();
        bus.out_latch = 1'b1;
        @(negedge clk);
        chk("latch_before", 64'(bus.final_output), 64'h0);
        cyc();
        @(negedge clk);
        chk("latch_r0", 64'(bus.final_output), 64'h42);
        cyc();
        wr_wb(2'd0, 8'h55); bus.out_latch = 1'b1;
        cyc();
        @(negedge clk);
        chk("latch_bypassed", 64'(bus.final_output), 64'h55);
        cyc();
        wr_wb(2'd0, 8'h66);
        cyc();
        @(negedge clk);
        chk("latch_hold", 64'(bus.final_output), 64'h55);

        cyc();
        wr_wb(2'd3, 8'h12); wr_dm(2'd3, 8'h34); wr_li(2'd1, 8'h56);
        bus.rd_a_addr = 2'd3; bus.rd_b_addr = 2'd1;
        @(negedge clk);
        chk("par_rd_a", 64'(bus.rd_a_data), 64'h34);
        chk("par_rd_b", 64'(bus.rd_b_data), 64'h56);
        cyc();
        @(negedge clk);
        chk("par_dump", 64'(bus.reg_dump), 64'h34005666);

        cyc();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
